// File: rtl/i2s_sched_pkg.sv
// i2s_sched_pkg: shared state encoding and width defaults for the I2S buffer scheduler
package i2s_sched_pkg;
    localparam int ADDR_WIDTH_DEF = 32;
    localparam int SIZE_WIDTH_DEF = 24;
    localparam int WORD_BYTES = 4;
    localparam int WORD_SHIFT = $clog2(WORD_BYTES);
    typedef enum logic [2:0] {IDLE, SETUP, READ, FINISH, WAIT_DROP} state_t;
endpackage

// File: rtl/i2s_buf_descriptor.sv
// i2s_buf_descriptor: one armable audio buffer holding base, size, read offset and ready flag
module i2s_buf_descriptor
    import i2s_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int SIZE_WIDTH = SIZE_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_arm,
    input  logic [ADDR_WIDTH-1:0] i_base,
    input  logic [SIZE_WIDTH-1:0] i_size,
    input  logic                  i_advance,
    output logic                  o_ready,
    output logic                  o_arm_err,
    output logic                  o_exhausted_next,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [SIZE_WIDTH-1:0] o_remaining
);
    logic [ADDR_WIDTH-1:0] r_base;
    logic [SIZE_WIDTH-1:0] r_size;
    logic [SIZE_WIDTH-1:0] r_offset;
    logic                  r_ready;
    logic                  w_accept;

    assign w_accept         = i_arm && !r_ready && (i_size != '0);
    assign o_arm_err        = i_arm && !w_accept;
    assign o_ready          = r_ready;
    assign o_exhausted_next = r_ready && (r_offset + SIZE_WIDTH'(1) == r_size);
    assign o_addr           = r_base + (ADDR_WIDTH'(r_offset) << WORD_SHIFT);
    assign o_remaining      = r_size - r_offset;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base   <= '0;
            r_size   <= '0;
            r_offset <= '0;
            r_ready  <= 1'b0;
        end else if (w_accept) begin
            r_base   <= i_base;
            r_size   <= i_size;
            r_offset <= '0;
            r_ready  <= 1'b1;
        end else if (i_advance && r_ready) begin
            r_offset <= r_offset + SIZE_WIDTH'(1);
            r_ready  <= !o_exhausted_next;
        end
    end
endmodule

// File: rtl/i2s_buffer_scheduler.sv
// i2s_buffer_scheduler: ping-pong buffer scheduler streaming memory words to the I2S memory controller
module i2s_buffer_scheduler
    import i2s_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int SIZE_WIDTH = SIZE_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [1:0]            buf_arm,
    input  logic [ADDR_WIDTH-1:0] buf_base,
    input  logic [SIZE_WIDTH-1:0] buf_size,
    input  logic                  clear_status,
    input  logic                  request_data,
    input  logic [SIZE_WIDTH-1:0] request_size,
    output logic                  request_finished,
    output logic [31:0]           memory_data,
    output logic                  memory_data_strobe,
    output logic                  mem_rd_stb,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_rd_ack,
    input  logic [31:0]           mem_rd_data,
    output logic [1:0]            buf_done,
    output logic                  arm_err,
    output logic [1:0]            buf_ready,
    output logic                  active_buf,
    output logic                  underrun,
    output logic                  busy
);
    state_t                r_state, w_state_next;
    logic                  r_active, w_toggle;
    logic [SIZE_WIDTH-1:0] r_xfer_cnt, w_xfer_next;
    logic                  r_gap, w_gap_next;
    logic                  r_underrun, w_underrun_set;
    logic [31:0]           r_mem_data;
    logic                  r_data_stb, r_arm_err;
    logic [1:0]            r_buf_done, w_done;
    logic [1:0]            w_ready, w_exh, w_arm_err;
    logic [ADDR_WIDTH-1:0] w_addr [2];
    logic [SIZE_WIDTH-1:0] w_rem [2];
    logic [SIZE_WIDTH-1:0] w_rem_act;
    logic                  w_stb, w_ack;

    for (genvar i = 0; i < 2; i++) begin : g_desc
        i2s_buf_descriptor #(
            .ADDR_WIDTH(ADDR_WIDTH),
            .SIZE_WIDTH(SIZE_WIDTH)
        ) u_desc (
            .clk              (clk),
            .rst              (rst),
            .i_arm            (buf_arm[i]),
            .i_base           (buf_base),
            .i_size           (buf_size),
            .i_advance        (w_ack && (r_active == 1'(i))),
            .o_ready          (w_ready[i]),
            .o_arm_err        (w_arm_err[i]),
            .o_exhausted_next (w_exh[i]),
            .o_addr           (w_addr[i]),
            .o_remaining      (w_rem[i])
        );
    end

    // r_gap forces the one idle strobe cycle between consecutive words
    assign w_stb              = (r_state == READ) && !r_gap;
    assign w_ack              = w_stb && mem_rd_ack;
    assign w_rem_act          = w_rem[r_active];
    assign mem_rd_stb         = w_stb;
    assign mem_addr           = w_stb ? w_addr[r_active] : '0;
    assign request_finished   = (r_state == FINISH);
    assign busy               = (r_state != IDLE);
    assign memory_data        = r_mem_data;
    assign memory_data_strobe = r_data_stb;
    assign buf_done           = r_buf_done;
    assign arm_err            = r_arm_err;
    assign buf_ready          = w_ready;
    assign active_buf         = r_active;
    assign underrun           = r_underrun;

    always_comb begin
        w_state_next   = r_state;
        w_toggle       = 1'b0;
        w_underrun_set = 1'b0;
        w_xfer_next    = r_xfer_cnt;
        w_gap_next     = 1'b0;
        w_done         = 2'b00;
        case (r_state)
            IDLE: begin
                if (enable && request_data) begin
                    if (request_size == '0) begin
                        w_state_next = FINISH;
                    end else if (w_ready[r_active]) begin
                        w_state_next = SETUP;
                    end else if (w_ready[~r_active]) begin
                        w_toggle     = 1'b1;
                        w_state_next = SETUP;
                    end else begin
                        w_underrun_set = 1'b1;
                    end
                end
            end
            SETUP: begin
                w_xfer_next  = (request_size < w_rem_act) ? request_size : w_rem_act;
                w_state_next = READ;
            end
            READ: begin
                // a strobe already on the bus always completes before leaving
                if (w_ack) begin
                    w_xfer_next = r_xfer_cnt - SIZE_WIDTH'(1);
                    if (w_exh[r_active]) begin
                        w_done[r_active] = 1'b1;
                        w_toggle         = 1'b1;
                        w_state_next     = FINISH;
                    end else if (r_xfer_cnt == SIZE_WIDTH'(1) || !enable) begin
                        w_state_next = FINISH;
                    end else begin
                        w_gap_next = 1'b1;
                    end
                end else if (!w_stb && !enable) begin
                    w_state_next = FINISH;
                end
            end
            FINISH:    w_state_next = WAIT_DROP;
            WAIT_DROP: w_state_next = request_data ? WAIT_DROP : IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_active   <= 1'b0;
            r_xfer_cnt <= '0;
            r_gap      <= 1'b0;
            r_underrun <= 1'b0;
            r_mem_data <= '0;
            r_data_stb <= 1'b0;
            r_buf_done <= 2'b00;
            r_arm_err  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_active   <= r_active ^ w_toggle;
            r_xfer_cnt <= w_xfer_next;
            r_gap      <= w_gap_next;
            r_underrun <= w_underrun_set || (r_underrun && !clear_status);
            r_data_stb <= w_ack;
            r_buf_done <= w_done;
            r_arm_err  <= |w_arm_err;
            if (w_ack) r_mem_data <= mem_rd_data;
        end
    end
endmodule

// File: tb/tb_i2s_buffer_scheduler.sv
// tb_i2s_buffer_scheduler: directed stimulus with a queue scoreboard checking reads and delivered words
module tb_i2s_buffer_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  buf_arm = 2'b00;
    logic [31:0] buf_base = '0;
    logic [23:0] buf_size = '0;
    logic        clear_status = 1'b0;
    logic        request_data = 1'b0;
    logic [23:0] request_size = '0;
    logic        mem_rd_ack = 1'b0;
    logic [31:0] mem_rd_data = '0;
    logic        request_finished, memory_data_strobe, mem_rd_stb, arm_err;
    logic        active_buf, underrun, busy;
    logic [31:0] memory_data, mem_addr;
    logic [1:0]  buf_done, buf_ready;

    i2s_buffer_scheduler #(.ADDR_WIDTH(32), .SIZE_WIDTH(24)) dut (
        .clk(clk), .rst(rst), .enable(enable), .buf_arm(buf_arm), .buf_base(buf_base),
        .buf_size(buf_size), .clear_status(clear_status), .request_data(request_data),
        .request_size(request_size), .request_finished(request_finished),
        .memory_data(memory_data), .memory_data_strobe(memory_data_strobe),
        .mem_rd_stb(mem_rd_stb), .mem_addr(mem_addr), .mem_rd_ack(mem_rd_ack),
        .mem_rd_data(mem_rd_data), .buf_done(buf_done), .arm_err(arm_err),
        .buf_ready(buf_ready), .active_buf(active_buf), .underrun(underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          lat = 0;
    int          mem_wait = 0;
    int          n_data = 0;
    int          fin_cnt = 0;
    logic [1:0]  done_seen = 2'b00;
    logic        seen_stb = 1'b0;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_rd(input logic [31:0] a);
        q_addr.push_back(a);
        q_data.push_back(mem_word(a));
    endtask

    task automatic arm(input logic [1:0] m, input logic [31:0] b, input logic [23:0] s,
                       input logic exp_err, input logic [1:0] exp_ready, input string name);
        buf_arm = m;
        buf_base = b;
        buf_size = s;
        tick(1);
        buf_arm = 2'b00;
        @(negedge clk);
        chk({name, "_arm_err"}, arm_err, exp_err);
        chk({name, "_ready"}, buf_ready, exp_ready);
        tick(1);
    endtask

    task automatic start_req(input logic [23:0] sz);
        n_data = 0;
        fin_cnt = 0;
        done_seen = 2'b00;
        seen_stb = 1'b0;
        request_size = sz;
        request_data = 1'b1;
    endtask

    task automatic wait_stb();
        for (int i = 0; i < 50 && !seen_stb; i++) tick(1);
        chk("stb_seen", seen_stb, 1'b1);
    endtask

    task automatic finish_req(input string name, input int exp_n, input logic [1:0] exp_done,
                              input logic exp_act, input logic [1:0] exp_ready);
        for (int i = 0; i < 300 && fin_cnt == 0; i++) tick(1);
        chk({name, "_finished"}, fin_cnt, 1);
        request_data = 1'b0;
        tick(3);
        chk({name, "_words"}, n_data, exp_n);
        chk({name, "_buf_done"}, done_seen, exp_done);
        chk({name, "_active"}, active_buf, exp_act);
        chk({name, "_ready"}, buf_ready, exp_ready);
        chk({name, "_idle"}, busy, 1'b0);
    endtask

    // memory slave: acks a held strobe after lat wait cycles
    initial forever begin
        @(posedge clk);
        #2;
        mem_rd_ack = 1'b0;
        if (mem_rd_stb) begin
            if (mem_wait >= lat) begin
                mem_rd_ack = 1'b1;
                mem_rd_data = mem_word(mem_addr);
                mem_wait = 0;
            end else begin
                mem_wait++;
            end
        end else begin
            mem_wait = 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_pend = 1'b0;
        end else begin
            if (prev_pend) begin
                chk("stb_hold", mem_rd_stb, 1'b1);
                chk("addr_hold", mem_addr, prev_addr);
            end
            if (mem_rd_stb) seen_stb = 1'b1;
            if (mem_rd_stb && mem_rd_ack) begin
                if (q_addr.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rd_addr: got read of %h expected no read", mem_addr);
                end else begin
                    chk("rd_addr", mem_addr, q_addr.pop_front());
                end
            end
            if (memory_data_strobe) begin
                n_data++;
                if (q_data.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rd_data: got word %h expected no word", memory_data);
                end else begin
                    chk("rd_data", memory_data, q_data.pop_front());
                end
            end
            if (request_finished) fin_cnt++;
            done_seen = done_seen | buf_done;
            prev_pend = mem_rd_stb && !mem_rd_ack;
            prev_addr = mem_addr;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", buf_ready, 2'b00);
        chk("rst_active", active_buf, 1'b0);
        chk("rst_underrun", underrun, 1'b0);
        chk("rst_stb", mem_rd_stb, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_outs", {request_finished, memory_data_strobe, arm_err, buf_done}, 5'b0);
        chk("rst_data", memory_data, 32'h0);
        tick(1);
        rst = 1'b0;
        enable = 1'b1;
        tick(1);

        arm(2'b01, 32'h1000, 24'd4, 1'b0, 2'b01, "t1");
        exp_rd(32'h1000); exp_rd(32'h1004); exp_rd(32'h1008); exp_rd(32'h100C);
        start_req(24'd4);
        finish_req("t1", 4, 2'b01, 1'b1, 2'b00);

        arm(2'b10, 32'h2000, 24'd3, 1'b0, 2'b10, "t2a");
        arm(2'b01, 32'h3000, 24'd8, 1'b0, 2'b11, "t2b");
        exp_rd(32'h2000); exp_rd(32'h2004); exp_rd(32'h2008);
        start_req(24'd5);
        finish_req("t2a", 3, 2'b10, 1'b0, 2'b01);
        exp_rd(32'h3000); exp_rd(32'h3004); exp_rd(32'h3008); exp_rd(32'h300C); exp_rd(32'h3010);
        start_req(24'd5);
        finish_req("t2b", 5, 2'b00, 1'b0, 2'b01);

        arm(2'b01, 32'hDEAD0000, 24'd16, 1'b1, 2'b01, "dup");
        arm(2'b10, 32'hBEEF0000, 24'd0, 1'b1, 2'b01, "zero");
        exp_rd(32'h3014); exp_rd(32'h3018); exp_rd(32'h301C);
        start_req(24'd8);
        finish_req("rem", 3, 2'b01, 1'b1, 2'b00);

        start_req(24'd2);
        tick(4);
        chk("ur_set", underrun, 1'b1);
        chk("ur_idle", busy, 1'b0);
        chk("ur_no_stb", seen_stb, 1'b0);
        exp_rd(32'h4000); exp_rd(32'h4004);
        arm(2'b10, 32'h4000, 24'd2, 1'b0, 2'b10, "ur");
        finish_req("ur", 2, 2'b10, 1'b0, 2'b00);
        chk("ur_sticky", underrun, 1'b1);
        clear_status = 1'b1;
        tick(1);
        clear_status = 1'b0;
        @(negedge clk);
        chk("ur_clear", underrun, 1'b0);
        tick(1);

        lat = 5;
        arm(2'b01, 32'h5000, 24'd4, 1'b0, 2'b01, "t6");
        exp_rd(32'h5000);
        start_req(24'd4);
        wait_stb();
        tick(2);
        enable = 1'b0;
        finish_req("t6", 1, 2'b00, 1'b0, 2'b01);
        enable = 1'b1;
        chk("t6_q_empty", q_addr.size(), 0);

        exp_rd(32'h5004);
        start_req(24'd4);
        wait_stb();
        tick(1);
        rst = 1'b1;
        #1;
        chk("rstmid_stb", mem_rd_stb, 1'b0);
        chk("rstmid_addr", mem_addr, 32'h0);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_ready", buf_ready, 2'b00);
        q_addr.delete();
        q_data.delete();
        lat = 0;
        tick(1);
        rst = 1'b0;
        seen_stb = 1'b0;
        tick(4);
        chk("post_rst_underrun", underrun, 1'b1);
        chk("post_rst_no_stb", seen_stb, 1'b0);
        chk("post_rst_idle", busy, 1'b0);
        request_data = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
